// File: rtl/alu_seq_if.sv
// ALU_SEQ handshake bundle: operation request channel and result channel.
`timescale 1ns/1ps
`default_nettype none

interface alu_seq_if #(
    parameter int WIDTH = 18
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       alu_select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             illegal;

    modport master (
        output in_valid, operand1, operand2, alu_select, out_ready,
        input  in_ready, out_valid, result, flags, illegal
    );

    modport slave (
        input  in_valid, operand1, operand2, alu_select, out_ready,
        output in_ready, out_valid, result, flags, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
// ==========================================================================
// Module : alu_seq
// Brief  : Sequential ALU, single-cycle ops plus iterative shift-add multiply.
// Rev    : 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_seq #(
    parameter int WIDTH  = 18,
    parameter int MUL_EN = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_AND  = 3'b001;
    localparam logic [2:0] c_OP_NAND = 3'b010;
    localparam logic [2:0] c_OP_NOR  = 3'b011;
    localparam logic [2:0] c_OP_SUB  = 3'b100;
    localparam logic [2:0] c_OP_XOR  = 3'b101;
    localparam logic [2:0] c_OP_SHL  = 3'b110;
    localparam logic [2:0] c_OP_MUL  = 3'b111;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam bit c_MUL_ON = (MUL_EN != 0);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_live;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_illegal;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_is_mul = (bus.alu_select == c_OP_MUL);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next = (w_is_mul && c_MUL_ON) ? c_BUSY : c_DONE;
                end
            end
            c_BUSY: begin
                if (r_cnt == c_LAST) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                if (bus.out_ready) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // r_live keeps in_ready low until the first edge after reset release.
    always_comb begin
        w_in_ready  = r_live && (r_state == c_IDLE);
        w_out_valid = (r_state == c_DONE);
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
    assign bus.illegal   = r_illegal;

    // ---------------- single-cycle datapath ----------------
    assign w_add = {1'b0, bus.operand1} + {1'b0, bus.operand2};
    assign w_sub = {1'b0, bus.operand1} - {1'b0, bus.operand2};
    // Bit WIDTH of the widened shift is the last bit pushed out of the MSB.
    assign w_shl = {1'b0, bus.operand1} << bus.operand2[4:0];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.alu_select)
            c_OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                        (w_add[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            c_OP_AND:  w_res = bus.operand1 & bus.operand2;
            c_OP_NAND: w_res = ~(bus.operand1 & bus.operand2);
            c_OP_NOR:  w_res = ~(bus.operand1 | bus.operand2);
            c_OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = ~w_sub[WIDTH];
                w_v   = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != bus.operand1[WIDTH-1]);
            end
            c_OP_XOR: w_res = bus.operand1 ^ bus.operand2;
            c_OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // ---------------- result and multiply registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live    <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul && c_MUL_ON) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, bus.operand1};
                            r_mplier <= bus.operand2;
                            r_cnt    <= '0;
                        end else if (w_is_mul) begin
                            r_result  <= '0;
                            r_flags   <= '0;
                            r_illegal <= 1'b1;
                        end else begin
                            r_result  <= w_res;
                            r_flags   <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
                            r_illegal <= 1'b0;
                        end
                    end
                end
                c_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result  <= w_acc_next[WIDTH-1:0];
                        r_flags   <= {w_acc_next[WIDTH-1],
                                      (w_acc_next[WIDTH-1:0] == '0),
                                      (|w_acc_next[2*WIDTH-1:WIDTH]),
                                      1'b0};
                        r_illegal <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

`default_nettype wire
